// File: rtl/serial_frame_deser_pkg.sv
// Shared types and constants for the serial frame deserializer.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;

    // Counter must be able to hold the value DATA_W itself.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/serial_frame_deser_if.sv
// Serial input stream plus word/status outputs of the deserializer.
// The slave modport is the deserializer side; the master is its environment.
interface serial_frame_deser_if #(parameter int DATA_W = 4);

    logic              bit_valid;
    logic              bit_in;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              frame_err;
    logic              overrun;
    logic              parity_err;
    logic              busy;

    modport master (
        output bit_valid, bit_in, out_ready,
        input  out_data, out_valid, frame_err, overrun, parity_err, busy
    );

    modport slave (
        input  bit_valid, bit_in, out_ready,
        output out_data, out_valid, frame_err, overrun, parity_err, busy
    );

endinterface

// File: rtl/serial_frame_deser_out_buf.sv
// Single-entry valid/ready holding register; drop pulses when a load hits a full, stalled buffer.
module frame_out_buf #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              drop
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              drop_q, drop_d;

    // A handshake in the same cycle as a load frees the slot for the new word.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        drop_d  = 1'b0;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            if (!valid_q || out_ready) begin
                data_d  = load_data;
                valid_d = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign drop      = drop_q;

endmodule

// File: rtl/serial_frame_deser.sv
// Start/stop framed serial-to-parallel deserializer, LSB first.
// Optional even-parity bit enabled by defining SERIAL_DESER_PARITY_EN.
module serial_frame_deser
    import serial_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input logic                 clk,
    input logic                 rst,
    serial_frame_deser_if.slave bus
);

    localparam int CNT_W = cnt_width(DATA_W);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              frame_err_q, frame_err_d;
    logic              load;
`ifdef SERIAL_DESER_PARITY_EN
    logic              parity_q, parity_d;
    logic              parity_err_q, parity_err_d;
`endif

    // Shifting in from the top leaves the first data bit in bit 0 after DATA_W bits.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        load        = 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
        parity_d     = parity_q;
        parity_err_d = 1'b0;
`endif
        if (bus.bit_valid) begin
            case (state_q)
                IDLE: begin
                    if (bus.bit_in == START_BIT) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shreg_d = {bus.bit_in, shreg_q[DATA_W-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef SERIAL_DESER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
`ifdef SERIAL_DESER_PARITY_EN
                PARITY: begin
                    parity_d = bus.bit_in;
                    state_d  = STOP;
                end
`endif
                STOP: begin
                    state_d     = IDLE;
                    frame_err_d = (bus.bit_in != STOP_BIT);
`ifdef SERIAL_DESER_PARITY_EN
                    parity_err_d = ^{shreg_q, parity_q};
                    load         = !frame_err_d && !parity_err_d;
`else
                    load         = !frame_err_d;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= {DATA_W{IDLE_LEVEL}};
            frame_err_q <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
            parity_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
`ifdef SERIAL_DESER_PARITY_EN
            parity_q     <= parity_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    frame_out_buf #(.DATA_W(DATA_W)) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (shreg_q),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .drop      (bus.overrun)
    );

    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != IDLE);
`ifdef SERIAL_DESER_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_deser.sv
// Scoreboard bench for serial_frame_deser: frame-level reference model feeds queues, a monitor checks.
// Parity expectations follow SERIAL_DESER_PARITY_EN.
module tb_serial_frame_deser;

    localparam int DATA_W = 4;
`ifdef SERIAL_DESER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NBITS = DATA_W + (PAR ? 1 : 0);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_frame_deser_if #(.DATA_W(DATA_W)) bus ();

    serial_frame_deser #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } word_t;

    typedef struct {
        bit f;
        bit p;
        bit o;
        int cyc;
    } err_t;

    word_t exp_words[$];
    err_t  exp_errs[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit m_in_frame = 1'b0;
    bit m_bits[$];
    bit m_valid    = 1'b0;
    int ready_mode = 1;

    always @(posedge clk) cyc = cyc + 1;

    // Reference model: frames are collected as bit lists and judged as a whole at the stop bit.
    task automatic modelEdge();
        bit accept;
        bit loaded;
        if (rst) begin
            m_in_frame = 1'b0;
            m_bits.delete();
            m_valid = 1'b0;
            return;
        end
        accept = m_valid && bus.out_ready;
        loaded = 1'b0;
        if (bus.bit_valid) begin
            if (!m_in_frame) begin
                if (bus.bit_in) begin
                    m_in_frame = 1'b1;
                    m_bits.delete();
                end
            end else if (m_bits.size() < NBITS) begin
                m_bits.push_back(bus.bit_in);
            end else begin
                int                ones;
                logic [DATA_W-1:0] w;
                bit                ferr, perr, ovr;
                ones = 0;
                w    = '0;
                for (int i = 0; i < NBITS; i++) ones += int'(m_bits[i]);
                for (int i = 0; i < DATA_W; i++) if (m_bits[i]) w = w + DATA_W'(1 << i);
                ferr = bus.bit_in;
                perr = PAR && (ones % 2 != 0);
                ovr  = 1'b0;
                m_in_frame = 1'b0;
                if (!ferr && !perr) begin
                    if (!m_valid || accept) begin
                        m_valid = 1'b1;
                        loaded  = 1'b1;
                        exp_words.push_back('{w, cyc + 1});
                    end else begin
                        ovr = 1'b1;
                    end
                end
                if (ferr || perr || ovr) exp_errs.push_back('{ferr, perr, ovr, cyc + 1});
            end
        end
        if (accept && !loaded) m_valid = 1'b0;
    endtask

    task automatic fail(input string name, input int got, input int want);
        errors++;
        $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
    endtask

    task automatic checkOutput(input bit was_rst);
        if (was_rst) begin
            checks++;
            if ({bus.out_data, bus.out_valid, bus.frame_err, bus.overrun, bus.parity_err, bus.busy} != '0)
                fail("reset_outputs",
                     int'({bus.out_data, bus.out_valid, bus.frame_err, bus.overrun, bus.parity_err, bus.busy}), 0);
        end
        checks++;
        if (bus.busy !== m_in_frame) fail("busy", int'(bus.busy), int'(m_in_frame));
        checks++;
        if (bus.out_valid !== m_valid) fail("out_valid", int'(bus.out_valid), int'(m_valid));
    endtask

    task automatic applyStimulus(input bit r, input bit v, input bit b, input bit rdy);
        rst           = r;
        bus.bit_valid = v;
        bus.bit_in    = b;
        bus.out_ready = rdy;
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput(r);
    endtask

    function automatic bit pickReady();
        case (ready_mode)
            0:       return bit'($urandom_range(0, 1));
            1:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic sendBit(input bit b, input int gap_mode);
        int n;
        n = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (n) applyStimulus(1'b0, 1'b0, bit'($urandom_range(0, 1)), pickReady());
        applyStimulus(1'b0, 1'b1, b, pickReady());
    endtask

    task automatic sendFrame(input logic [DATA_W-1:0] w, input bit stop_b, input bit par_ok,
                             input int gap_mode);
        sendBit(1'b1, gap_mode);
        for (int i = 0; i < DATA_W; i++) sendBit(w[i], gap_mode);
        if (PAR) sendBit((^w) ^ !par_ok, gap_mode);
        sendBit(stop_b, gap_mode);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, bit'($urandom_range(0, 1)), 1'b0, pickReady());
    endtask

    // Monitor: every pulse and every newly presented word must match the queue head, on time.
    bit                prev_valid = 1'b0;
    bit                prev_hs    = 1'b0;
    logic [DATA_W-1:0] held_exp   = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            while (exp_errs.size() > 0 && exp_errs[0].cyc < cyc) begin
                checks++;
                fail("missed_pulse", 0, exp_errs[0].cyc);
                void'(exp_errs.pop_front());
            end
            while (exp_words.size() > 0 && exp_words[0].cyc < cyc) begin
                checks++;
                fail("missed_word", 0, int'(exp_words[0].data));
                void'(exp_words.pop_front());
            end
            if (bus.frame_err || bus.parity_err || bus.overrun) begin
                checks++;
                if (exp_errs.size() == 0) begin
                    fail("unexpected_pulse", int'({bus.frame_err, bus.parity_err, bus.overrun}), 0);
                end else begin
                    err_t e;
                    e = exp_errs.pop_front();
                    if ({bus.frame_err, bus.parity_err, bus.overrun} != {e.f, e.p, e.o} || e.cyc != cyc)
                        fail("pulse_fpo", int'({bus.frame_err, bus.parity_err, bus.overrun}),
                             int'({e.f, e.p, e.o}));
                end
            end
            if (bus.out_valid && (!prev_valid || prev_hs)) begin
                checks++;
                if (exp_words.size() == 0) begin
                    fail("unexpected_word", int'(bus.out_data), 0);
                end else begin
                    word_t w;
                    w = exp_words.pop_front();
                    held_exp = w.data;
                    if (bus.out_data !== w.data || w.cyc != cyc)
                        fail("word_data", int'(bus.out_data), int'(w.data));
                end
            end else if (bus.out_valid) begin
                checks++;
                if (bus.out_data !== held_exp) fail("word_hold", int'(bus.out_data), int'(held_exp));
            end
            prev_valid = bus.out_valid;
            prev_hs    = bus.out_valid && bus.out_ready;
        end
    end

    initial begin
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        bus.out_ready = 1'b0;

        // Reset with a noisy line, then a quiet idle line.
        ready_mode = 1;
        repeat (2) applyStimulus(1'b1, 1'b1, bit'($urandom_range(0, 1)), 1'b1);
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);

        // Basic frame, bad stop bit, then recovery.
        sendFrame(4'hD, 1'b0, 1'b1, 0);
        idle(3);
        sendFrame(4'h5, 1'b1, 1'b1, 0);
        idle(3);
        sendFrame(4'h5, 1'b0, 1'b1, 0);
        idle(3);

        // Stalled consumer: second frame overruns, then a single accept drains.
        ready_mode = 2;
        sendFrame(4'hA, 1'b0, 1'b1, 0);
        idle(2);
        sendFrame(4'h3, 1'b0, 1'b1, 0);
        idle(2);
        ready_mode = 1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        ready_mode = 2;
        idle(2);
        ready_mode = 1;

        // Alternating bit_valid with noise on invalid cycles.
        sendFrame(4'hD, 1'b0, 1'b1, 1);
        idle(3);

        // Reset after two data bits discards the partial frame silently.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, bit'($urandom_range(0, 1)), 1'b1);
        idle(2);
        sendFrame(4'h6, 1'b0, 1'b1, 0);
        idle(3);

        // Parity good and bad (without parity the bad case is just another good frame).
        sendFrame(4'hD, 1'b0, 1'b1, 0);
        idle(3);
        sendFrame(4'hD, 1'b0, 1'b0, 0);
        idle(3);

        // Random traffic with gaps, random back-pressure and injected errors.
        ready_mode = 0;
        repeat (60) begin
            sendFrame(DATA_W'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0), 2);
            idle(int'($urandom_range(0, 3)));
        end

        ready_mode = 1;
        idle(10);
        checks++;
        if (exp_words.size() != 0) fail("words_left", exp_words.size(), 0);
        checks++;
        if (exp_errs.size() != 0) fail("pulses_left", exp_errs.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
